wb_stage_pipe: RTL and testbench

//  Parametrised MEM/WB pipeline register and write-back selector for the bluex core.

---
 rtl/wb_stage_pipe.sv | 229 ++++++++++++++++++++++
 tb/tb_wb_stage_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_pipe
// Purpose  : MEM/WB pipeline register and write-back selector for the bluex
//            core. Captures NUM_SRC write-back sources plus control, then
//            selects one source combinationally. The load source (MEM_SRC)
//            is lane-aligned (byte/half/word/dword) and sign/zero-extended.
//            Supports stall, flush (bubble insert), valid tracking, x0 write
//            suppression and a retire counter.
// Ports    :
//   clk               in   rising-edge clock
//   rst_n             in   asynchronous reset, active low
//   enable_CPU        in   global enable; low freezes all state
//   stall             in   hold current contents
//   flush             in   load a bubble (overrides stall)
//   valid_in          in   incoming instruction is valid
//   src_data_in       in   source k at [k*DATA_W +: DATA_W]
//   src_sel_in        in   write-back source select
//   mem_size_in       in   00 byte, 01 half, 10 word, 11 dword
//   mem_unsigned_in   in   1 zero-extend, 0 sign-extend
//   byte_off_in       in   load address low bits
//   write_reg_addr_in in   destination register
//   reg_write_in      in   destination write request
//   write_back_data   out  selected, formatted write-back data
//   write_reg_addr    out  registered destination address
//   reg_write         out  register-file write enable
//   wb_valid          out  stage holds a valid instruction
//   retire_cnt        out  count of valid instructions retired
// Revision : 1.0  initial release
// ============================================================================
module wb_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_SRC  = 4,
  parameter int SEL_W    = 2,
  parameter int MEM_SRC  = 1,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 32,
  localparam int OFF_W   = $clog2(DATA_W / 8)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable_CPU,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      valid_in,
  input  logic [NUM_SRC*DATA_W-1:0] src_data_in,
  input  logic [SEL_W-1:0]          src_sel_in,
  input  logic [1:0]                mem_size_in,
  input  logic                      mem_unsigned_in,
  input  logic [OFF_W-1:0]          byte_off_in,
  input  logic [ADDR_W-1:0]         write_reg_addr_in,
  input  logic                      reg_write_in,
  output logic [DATA_W-1:0]         write_back_data,
  output logic [ADDR_W-1:0]         write_reg_addr,
  output logic                      reg_write,
  output logic                      wb_valid,
  output logic [CNT_W-1:0]          retire_cnt
);

  // Offset masks that drop the sub-lane bits for half and word accesses.
  localparam logic [OFF_W-1:0] HALF_ALIGN = ~OFF_W'(1);
  localparam logic [OFF_W-1:0] WORD_ALIGN = ~OFF_W'(3);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic                      valid_q,        valid_d;
  logic                      reg_write_q,    reg_write_d;
  logic [NUM_SRC*DATA_W-1:0] src_data_q,     src_data_d;
  logic [SEL_W-1:0]          src_sel_q,      src_sel_d;
  logic [1:0]                mem_size_q,     mem_size_d;
  logic                      mem_unsigned_q, mem_unsigned_d;
  logic [OFF_W-1:0]          byte_off_q,     byte_off_d;
  logic [ADDR_W-1:0]         addr_q,         addr_d;
  logic [CNT_W-1:0]          cnt_q,          cnt_d;

  // Priority: disabled hold > flush > stall hold > load.
  // A flush only kills valid and the write request; the payload registers
  // keep their old contents since nothing downstream consumes them.
  always_comb begin
    valid_d        = valid_q;
    reg_write_d    = reg_write_q;
    src_data_d     = src_data_q;
    src_sel_d      = src_sel_q;
    mem_size_d     = mem_size_q;
    mem_unsigned_d = mem_unsigned_q;
    byte_off_d     = byte_off_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    if (enable_CPU) begin
      if (flush) begin
        valid_d     = 1'b0;
        reg_write_d = 1'b0;
      end else if (!stall) begin
        // The held instruction leaves the stage on this edge.
        if (valid_q) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        valid_d        = valid_in;
        reg_write_d    = reg_write_in;
        src_data_d     = src_data_in;
        src_sel_d      = src_sel_in;
        mem_size_d     = mem_size_in;
        mem_unsigned_d = mem_unsigned_in;
        byte_off_d     = byte_off_in;
        addr_d         = write_reg_addr_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= 1'b0;
      reg_write_q    <= 1'b0;
      src_data_q     <= '0;
      src_sel_q      <= '0;
      mem_size_q     <= '0;
      mem_unsigned_q <= 1'b0;
      byte_off_q     <= '0;
      addr_q         <= '0;
      cnt_q          <= '0;
    end else begin
      valid_q        <= valid_d;
      reg_write_q    <= reg_write_d;
      src_data_q     <= src_data_d;
      src_sel_q      <= src_sel_d;
      mem_size_q     <= mem_size_d;
      mem_unsigned_q <= mem_unsigned_d;
      byte_off_q     <= byte_off_d;
      addr_q         <= addr_d;
      cnt_q          <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Load formatting of the memory source
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_word;
  logic [DATA_W-1:0] mem_shifted;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] fmt_data;
  logic [OFF_W-1:0]  off_eff;
  logic              sign_bit;

  always_comb begin
    mem_word  = src_data_q[MEM_SRC*DATA_W +: DATA_W];
    off_eff   = byte_off_q;
    lane_mask = DATA_W'(8'hFF);
    case (mem_size_q)
      SIZE_BYTE: begin
        off_eff   = byte_off_q;
        lane_mask = DATA_W'(8'hFF);
      end
      SIZE_HALF: begin
        off_eff   = byte_off_q & HALF_ALIGN;
        lane_mask = DATA_W'(16'hFFFF);
      end
      SIZE_WORD: begin
        off_eff   = byte_off_q & WORD_ALIGN;
        lane_mask = DATA_W'(32'hFFFF_FFFF);
      end
      default: begin
        // Dword on a 32-bit core degenerates to a word access.
        if (DATA_W == 64) begin
          off_eff   = '0;
          lane_mask = '1;
        end else begin
          off_eff   = byte_off_q & WORD_ALIGN;
          lane_mask = DATA_W'(32'hFFFF_FFFF);
        end
      end
    endcase

    // Shift the addressed lane down to bit 0, then mask and extend.
    mem_shifted = mem_word >> {off_eff, 3'b000};
    case (mem_size_q)
      SIZE_BYTE: sign_bit = mem_shifted[7];
      SIZE_HALF: sign_bit = mem_shifted[15];
      SIZE_WORD: sign_bit = mem_shifted[31];
      default:   sign_bit = mem_shifted[DATA_W-1];
    endcase

    fmt_data = mem_shifted & lane_mask;
    if (!mem_unsigned_q && sign_bit) begin
      fmt_data = fmt_data | ~lane_mask;
    end
  end

  // --------------------------------------------------------------------------
  // Source selection
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_sel_q == SEL_W'(k)) begin
        sel_data = src_data_q[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    if (int'(src_sel_q) >= NUM_SRC) begin
      write_back_data = '0;
    end else if (int'(src_sel_q) == MEM_SRC) begin
      write_back_data = fmt_data;
    end else begin
      write_back_data = sel_data;
    end
  end

  // --------------------------------------------------------------------------
  // Control outputs
  // --------------------------------------------------------------------------
  logic addr_is_zero;
  assign addr_is_zero   = (addr_q == '0);
  assign write_reg_addr = addr_q;
  assign wb_valid       = valid_q;
  assign retire_cnt     = cnt_q;
  assign reg_write      = valid_q & reg_write_q & ~((ZERO_REG != 0) & addr_is_zero);

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage_pipe
// Purpose  : Self-checking bench for wb_stage_pipe. Instance A uses the
//            default configuration (x0 suppression, four sources); instance
//            B has ZERO_REG=0 and NUM_SRC=3. Both use a 4-bit retire counter
//            so wrap-around is reachable in a few cycles.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_stage_pipe;

  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en, stall, flush, valid_in, uns, we;
  logic [127:0] src;
  logic [1:0]   sel, size, off;
  logic [4:0]   addr;

  logic [31:0]   wbd_a, wbd_b;
  logic [4:0]    addr_a, addr_b;
  logic          rw_a, rw_b, v_a, v_b;
  logic [CW-1:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  wb_stage_pipe #(.CNT_W(CW)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable_CPU(en), .stall(stall), .flush(flush),
    .valid_in(valid_in), .src_data_in(src), .src_sel_in(sel),
    .mem_size_in(size), .mem_unsigned_in(uns), .byte_off_in(off),
    .write_reg_addr_in(addr), .reg_write_in(we),
    .write_back_data(wbd_a), .write_reg_addr(addr_a), .reg_write(rw_a),
    .wb_valid(v_a), .retire_cnt(cnt_a)
  );

  wb_stage_pipe #(.ZERO_REG(0), .NUM_SRC(3), .CNT_W(CW)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable_CPU(en), .stall(stall), .flush(flush),
    .valid_in(valid_in), .src_data_in(src[95:0]), .src_sel_in(sel),
    .mem_size_in(size), .mem_unsigned_in(uns), .byte_off_in(off),
    .write_reg_addr_in(addr), .reg_write_in(we),
    .write_back_data(wbd_b), .write_reg_addr(addr_b), .reg_write(rw_b),
    .wb_valid(v_b), .retire_cnt(cnt_b)
  );

  typedef struct packed {
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [4:0]  addr;
    logic        weq;
    logic        valid;
  } exp_t;

  exp_t          sb[$];
  exp_t          m_cur;
  logic [CW-1:0] m_cnt;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference load formatter for a 32-bit word.
  function automatic logic [31:0] fmt32(input logic [31:0] w, input logic [1:0] sz,
                                        input logic u, input logic [1:0] o);
    logic [7:0]  b;
    logic [15:0] h;
    case (sz)
      2'd0: begin
        b = w[o*8 +: 8];
        return u ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'd1: begin
        h = w[o[1]*16 +: 16];
        return u ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: return w;
    endcase
  endfunction

  function automatic exp_t model();
    exp_t        e;
    logic [31:0] v;
    v = (sel == 2'd1) ? fmt32(src[63:32], size, uns, off) : src[sel*32 +: 32];
    e.data_a = v;
    e.data_b = (sel == 2'd3) ? 32'h0 : v;
    e.addr   = addr;
    e.weq    = we;
    e.valid  = valid_in;
    return e;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".data_a"}, wbd_a, m_cur.data_a);
    chk({tag, ".data_b"}, wbd_b, m_cur.data_b);
    chk({tag, ".addr"},   {addr_a, addr_b}, {m_cur.addr, m_cur.addr});
    chk({tag, ".rw_a"},   rw_a, m_cur.valid & m_cur.weq & (m_cur.addr != 5'd0));
    chk({tag, ".rw_b"},   rw_b, m_cur.valid & m_cur.weq);
    chk({tag, ".valid"},  {v_a, v_b}, {m_cur.valid, m_cur.valid});
    chk({tag, ".cnt"},    {cnt_a, cnt_b}, {m_cnt, m_cnt});
  endtask

  // One clock: the expected result of a load is queued when it is driven and
  // retired from the queue once the DUT presents it after the edge.
  task automatic tick(input string tag);
    logic ld, inc;
    inc = en && !stall && !flush && m_cur.valid;
    ld  = en && !flush && !stall;
    if (ld) sb.push_back(model());
    @(posedge clk);
    #1;
    if (inc) m_cnt++;
    if (ld) begin
      if (sb.size() == 0) chk({tag, ".sb_empty"}, 1, 0);
      else m_cur = sb.pop_front();
    end else if (en && flush) begin
      m_cur.valid = 1'b0;
      m_cur.weq   = 1'b0;
    end
    check_all(tag);
  endtask

  task automatic set_in(input logic [127:0] s, input logic [1:0] sl, input logic [1:0] sz,
                        input logic u, input logic [1:0] o, input logic [4:0] a,
                        input logic w, input logic v);
    src = s; sel = sl; size = sz; uns = u; off = o; addr = a; we = w; valid_in = v;
  endtask

  localparam logic [127:0] MEMV = 128'h8081_8283 << 32;

  initial begin
    en = 1'b1; stall = 1'b0; flush = 1'b0;
    set_in('0, 2'd0, 2'd2, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    m_cur = '0;
    m_cnt = '0;

    // Reset state
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // Plain ALU pass-through
    set_in(128'h1234_5678, 2'd0, 2'd2, 1'b0, 2'd0, 5'd5, 1'b1, 1'b1);
    tick("alu");
    chk("alu_data", wbd_a, 32'h1234_5678);

    // Load formatting
    set_in(MEMV, 2'd1, 2'd0, 1'b0, 2'd1, 5'd6, 1'b1, 1'b1);
    tick("lb_s1");
    chk("lb_s1_data", wbd_a, 32'hFFFF_FF82);
    set_in(MEMV, 2'd1, 2'd1, 1'b1, 2'd2, 5'd6, 1'b1, 1'b1);
    tick("lhu2");
    chk("lhu2_data", wbd_a, 32'h0000_8081);
    set_in(MEMV, 2'd1, 2'd2, 1'b0, 2'd3, 5'd6, 1'b1, 1'b1);
    tick("lw");
    chk("lw_data", wbd_a, 32'h8081_8283);
    set_in(MEMV, 2'd1, 2'd0, 1'b1, 2'd3, 5'd6, 1'b1, 1'b1);
    tick("lbu3");
    set_in(MEMV, 2'd1, 2'd1, 1'b0, 2'd1, 5'd6, 1'b1, 1'b1);
    tick("lh1");
    set_in(MEMV, 2'd1, 2'd3, 1'b0, 2'd0, 5'd6, 1'b1, 1'b1);
    tick("ld32");

    // x0 suppression
    set_in(128'hCAFE_0001 << 64, 2'd2, 2'd2, 1'b0, 2'd0, 5'd0, 1'b1, 1'b1);
    tick("x0");
    chk("x0_rw_a", rw_a, 1'b0);
    chk("x0_rw_b", rw_b, 1'b1);

    // Stall with changing inputs, then stall+flush
    set_in(128'hABCD, 2'd0, 2'd2, 1'b0, 2'd0, 5'd9, 1'b1, 1'b1);
    tick("pre_stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in({4{$urandom}}, 2'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
             5'($urandom), 1'b1, 1'b1);
      tick("stall");
    end
    chk("stall_data", wbd_a, 32'hABCD);
    flush = 1'b1;
    tick("stall_flush");
    chk("stall_flush_v", v_a, 1'b0);
    stall = 1'b0; flush = 1'b0;

    // Disabled with flush pending: nothing moves
    set_in(128'h5555, 2'd0, 2'd2, 1'b0, 2'd0, 5'd3, 1'b1, 1'b1);
    tick("pre_dis");
    en = 1'b0; flush = 1'b1;
    tick("disabled");
    chk("disabled_v", v_a, 1'b1);
    en = 1'b1; flush = 1'b0;

    // Retire counter wrap
    for (int i = 0; i < 40 && m_cnt != 4'hF; i++) begin
      set_in(128'(i), 2'd0, 2'd2, 1'b0, 2'd0, 5'd1, 1'b1, 1'b1);
      tick("cnt_run");
    end
    chk("cnt_at_max", cnt_a, 4'hF);
    tick("wrap0");
    chk("cnt_wrap0", cnt_a, 4'h0);
    tick("wrap1");
    chk("cnt_wrap1", cnt_a, 4'h1);

    // Mixed random traffic
    for (int i = 0; i < 40; i++) begin
      en    = ($urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      set_in({$urandom, $urandom, $urandom, $urandom}, 2'($urandom), 2'($urandom),
             1'($urandom), 2'($urandom), 5'($urandom), 1'($urandom),
             ($urandom_range(0, 3) != 0));
      tick("rand");
    end
    en = 1'b1; stall = 1'b0; flush = 1'b0;

    // Asynchronous reset between edges
    set_in(128'h7777, 2'd0, 2'd2, 1'b0, 2'd0, 5'd4, 1'b1, 1'b1);
    tick("pre_rst");
    #3 rst_n = 1'b0;
    #1;
    sb.delete();
    m_cur = '0;
    m_cnt = '0;
    check_all("midrst");
    #2 rst_n = 1'b1;

    // Select beyond NUM_SRC on the 3-source instance
    set_in(128'h0BAD_F00D << 96, 2'd3, 2'd2, 1'b0, 2'd0, 5'd8, 1'b1, 1'b1);
    tick("sel3");
    chk("sel3_b", wbd_b, 32'h0);
    chk("sel3_a", wbd_a, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
